ct_serializer: RTL and testbench
================================

Name: ct_serializer

Overview:
- Output stage directly downstream of the ROLLO-I encrypt core.
- After encryption completes, reads the ciphertext memory (`ct`, one word of DIGIT*M bits per address) through its read port.
- Packs the N*M valid ciphertext bits into one contiguous bitstream and streams it out as OUT_W-bit beats over a valid/ready handshake.
- Replaces the raw 32-bit slice of the memory output as the block's external data interface.

Parameters:
- M, 79, GF(2^m) element width in bits.
- N, 47, ciphertext length in elements.
- DIGIT, 4, elements per ct memory word; W = DIGIT*M.
- OUT_W, 32, output beat width.

Ports:
- clk  in  1  system clock.
- rst_b  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin serialising ct.
- ct_addr  out  CLOG2(D)  ct read address, D = ceil(N/DIGIT). Driven 0 whenever not reading, because the memory address bus is OR-shared.
- ct_rd  out  1  high in the cycle a read address is issued.
- ct_din  in  W  ct read data, valid one cycle after the address (synchronous read).
- dout  out  OUT_W  stream beat.
- dout_valid  out  1  beat valid.
- dout_ready  in  1  sink accepts the beat.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, any state): FSM to IDLE. ct_addr, ct_rd, dout, dout_valid, busy, done, buffer, fill and word counter all cleared.
- Bit order:
  - Element j of word a occupies ct_din[j*M +: M]; stream bit index = a*W + j*M + b.
  - Beat k carries stream bits [k*OUT_W +: OUT_W], LSB first.
  - Word D-1 contributes only LAST_BITS = N*M - (D-1)*W bits; its upper bits are discarded.
  - Total beats BEATS = ceil(N*M/OUT_W). Defaults: D=12, LAST_BITS=237, BEATS=117, final beat holds 1 valid bit, zero-padded.
- Buffer: shift register of W+OUT_W-1 bits plus fill counter (0..W+OUT_W-1).
- FSM states:
  - IDLE: start=1 -> FETCH; word counter = 0; busy=1 from next cycle. Start in any other state is ignored.
  - FETCH: ct_rd=1, ct_addr=word counter -> LOAD.
  - LOAD: ct_din appended at bit position fill; fill += W (or LAST_BITS on the final word); word counter +1 -> DRAIN.
  - DRAIN: dout_valid=1 while fill >= OUT_W, or while fill > 0 and all words are loaded (zero-padded flush beat). On a handshake the buffer shifts right by OUT_W and fill -= min(fill, OUT_W). Then:
    - fill < OUT_W and words remain -> FETCH.
    - fill = 0 and no words remain -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- dout and dout_valid are registered. Once dout_valid=1, dout is held stable until the handshake; valid never drops without a handshake.
- Latency:
  - Start sampled at cycle 0 -> FETCH at cycle 1 -> LOAD at cycle 2 -> dout_valid=1 at cycle 3.
  - With dout_ready held at 1, each refill costs exactly 2 idle cycles (FETCH, LOAD).
- Edge cases:
  - dout_ready=1 while dout_valid=0: no effect.
  - Reset mid-stream: stream aborts, no done pulse; the next start restarts from word 0.

Optional Feature:
- Macro: CT_SER_LAST_EN.
- Defined: adds output port dout_last (1 bit).
  - High together with dout_valid on beat BEATS-1 only; otherwise 0.
  - Reset value 0.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared package/define file (alongside the existing define and clog2 headers) holds:
  - derived constants W, D, LAST_BITS, TOTAL_BITS = N*M, BEATS;
  - FSM state encoding (IDLE, FETCH, LOAD, DRAIN, FIN);
  - CLOG2 use for ct_addr and fill widths.
- One sub-module, ct_bit_packer: buffer plus fill counter.
  - Inputs: load, load_bits, load_data, shift.
  - Outputs: head beat, fill.
  - The FSM stays in ct_serializer.

Test Plan:
1. Defaults, ct word a filled with a*0x01010101 pattern, dout_ready=1 -> exactly 117 beats matching the golden packing model; first valid 3 cycles after start; beat 116 = bit 3712 in bit0, bits[31:1]=0; done pulses 1 cycle after beat 116 handshake.
2. Random dout_ready (50%) -> same 117 beats; dout stable across every stalled cycle; no duplicated or dropped beat.
3. IDLE and FIN monitoring -> ct_addr=0 and ct_rd=0 every cycle outside FETCH; ct_addr sequence 0..11, each issued exactly once.
4. Second start pulse at beat 40 -> ignored; output identical to scenario 1; busy stays 1.
5. rst_b low at beat 60 -> all outputs 0 within the same cycle (async); no done; a new start yields the full 117-beat stream from beat 0.
6. CT_SER_LAST_EN defined -> dout_last=1 only on beat 116; undefined build compiles and passes scenarios 1-5.

Source files
------------

// File: rtl/ct_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ct_serializer_pkg
// Shared constants, FSM encoding and small helpers for the ROLLO-I
// ciphertext serializer (ct_serializer) and its bit packer (ct_bit_packer).
//   W          : ct memory word width (DIGIT elements of M bits)
//   D          : number of ct words holding N elements
//   LAST_BITS  : valid bits in the final word
//   TOTAL_BITS : ciphertext length in bits
//   BEATS      : number of OUT_W-bit output beats (last one zero-padded)
//   BUF_W      : packer buffer width; a full word can land on a residue of
//                up to OUT_W-1 bits
// Optional feature macro: CT_SER_LAST_EN (adds dout_last to the stream).
// ---------------------------------------------------------------------------
package ct_serializer_pkg;

    localparam int unsigned M     = 79;
    localparam int unsigned N     = 47;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned OUT_W = 32;

    localparam int unsigned W          = DIGIT * M;
    localparam int unsigned D          = (N + DIGIT - 1) / DIGIT;
    localparam int unsigned TOTAL_BITS = N * M;
    localparam int unsigned LAST_BITS  = TOTAL_BITS - (D - 1) * W;
    localparam int unsigned BEATS      = (TOTAL_BITS + OUT_W - 1) / OUT_W;
    localparam int unsigned BUF_W      = W + OUT_W - 1;

    localparam int unsigned ADDR_W = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned FILL_W = $clog2(BUF_W + 1);
    localparam int unsigned WCNT_W = $clog2(D + 1);

    typedef logic [FILL_W-1:0] fill_t;
    typedef logic [WCNT_W-1:0] wcnt_t;

    localparam fill_t OUT_W_F     = fill_t'(OUT_W);
    localparam fill_t W_F         = fill_t'(W);
    localparam fill_t LAST_BITS_F = fill_t'(LAST_BITS);
    localparam wcnt_t D_W         = wcnt_t'(D);
    localparam wcnt_t LAST_WORD   = wcnt_t'(D - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } ser_state_e;

    // Bits consumed by one accepted beat: a full beat, or the flush residue.
    function automatic fill_t beat_take(input fill_t fill);
        fill_t take;
        if (fill < OUT_W_F) begin
            take = fill;
        end else begin
            take = OUT_W_F;
        end
        return take;
    endfunction

    // A beat is offered when a full beat is buffered, or when only the
    // zero-padded tail is left after the last word has been loaded.
    function automatic logic beat_pending(input fill_t fill, input logic all_loaded);
        return (fill >= OUT_W_F) || ((fill != fill_t'(0)) && all_loaded);
    endfunction

    // The offered beat is the final one of the stream.
    function automatic logic beat_is_last(input fill_t fill, input logic all_loaded);
        return all_loaded && (fill != fill_t'(0)) && (fill <= OUT_W_F);
    endfunction

endpackage

// File: rtl/ct_serializer_if.sv
// ---------------------------------------------------------------------------
// ct_serializer_if
// Output stream of the ciphertext serializer (valid/ready handshake).
//   dout       : OUT_W-bit beat, stream bits LSB first
//   dout_valid : beat valid
//   dout_ready : sink accepts the beat
//   dout_last  : final beat marker (only with CT_SER_LAST_EN)
// Modports: master = serializer side, slave = sink side.
// ---------------------------------------------------------------------------
interface ct_serializer_if;

    logic [ct_serializer_pkg::OUT_W-1:0] dout;
    logic                                dout_valid;
    logic                                dout_ready;
`ifdef CT_SER_LAST_EN
    logic                                dout_last;
`endif

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
`ifdef CT_SER_LAST_EN
        ,
        output dout_last
`endif
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
`ifdef CT_SER_LAST_EN
        ,
        input  dout_last
`endif
    );

endinterface

// File: rtl/ct_bit_packer.sv
// ---------------------------------------------------------------------------
// ct_bit_packer
// Shift-register buffer with fill counter that concatenates variable-length
// ct words into a contiguous bitstream, head at bit 0.
// Ports:
//   clk, rst_b : clock, asynchronous active-low reset
//   load       : append load_data (low load_bits bits) at bit position fill
//   load_bits  : number of valid bits in load_data
//   load_data  : ct word
//   shift      : drop OUT_W bits from the head (fill saturates at 0)
//   head       : lowest OUT_W buffer bits (registered)
//   fill       : number of valid bits in the buffer
// Bits above fill are always zero, so a partial head is already zero-padded.
// ---------------------------------------------------------------------------
module ct_bit_packer
    import ct_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  fill_t            load_bits,
    input  logic [W-1:0]     load_data,
    input  logic             shift,
    output logic [OUT_W-1:0] head,
    output fill_t            fill
);

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_d;
    fill_t            fill_q;
    fill_t            fill_d;

    fill_t            gap_s;
    logic [W-1:0]     mask_s;
    logic [BUF_W-1:0] ext_s;

    // Next buffer contents: masked append at the fill point, or head drop.
    always_comb begin
        gap_s  = W_F - load_bits;
        mask_s = {W{1'b1}} >> gap_s;
        ext_s  = {{(BUF_W - W){1'b0}}, load_data & mask_s} << fill_q;
        buf_d  = buf_q;
        fill_d = fill_q;
        if (load) begin
            buf_d  = buf_q | ext_s;
            fill_d = fill_q + load_bits;
        end else if (shift) begin
            buf_d  = buf_q >> OUT_W;
            fill_d = fill_q - beat_take(fill_q);
        end else begin
            buf_d  = buf_q;
            fill_d = fill_q;
        end
    end

    // Buffer and fill registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign head = buf_q[OUT_W-1:0];
    assign fill = fill_q;

endmodule

// File: rtl/ct_serializer.sv
// ---------------------------------------------------------------------------
// ct_serializer
// Reads the ROLLO-I ciphertext memory after encryption and streams its
// N*M valid bits as OUT_W-bit beats over a valid/ready handshake.
// Ports:
//   clk, rst_b : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begin serialising (ignored while active)
//   ct_addr    : ct read address, forced to 0 when not reading (OR-shared bus)
//   ct_rd      : read strobe, high while the address is issued
//   ct_din     : ct read data, valid the cycle after the address
//   dout_if    : output stream (dout, dout_valid, dout_ready[, dout_last])
//   busy       : high from the cycle after start until done
//   done       : one-cycle pulse after the last beat is accepted
// Optional feature macro: CT_SER_LAST_EN adds dout_if.dout_last.
// ---------------------------------------------------------------------------
module ct_serializer
    import ct_serializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    output logic [ADDR_W-1:0]    ct_addr,
    output logic                 ct_rd,
    input  logic [W-1:0]         ct_din,
    ct_serializer_if.master      dout_if,
    output logic                 busy,
    output logic                 done
);

    ser_state_e        state_q;
    ser_state_e        state_d;
    wcnt_t             word_q;
    wcnt_t             word_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              valid_q;
    logic              valid_d;
    logic              rd_q;
    logic              rd_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
`ifdef CT_SER_LAST_EN
    logic              last_q;
    logic              last_d;
`endif

    logic              pk_load_s;
    logic              pk_shift_s;
    fill_t             pk_load_bits_s;
    fill_t             pk_fill_s;
    logic [OUT_W-1:0]  pk_head_s;
    fill_t             fill_next_s;
    logic              all_loaded_s;
    logic              handshake_s;

    assign handshake_s = valid_q & dout_if.dout_ready;

    ct_bit_packer u_packer (
        .clk       (clk),
        .rst_b     (rst_b),
        .load      (pk_load_s),
        .load_bits (pk_load_bits_s),
        .load_data (ct_din),
        .shift     (pk_shift_s),
        .head      (pk_head_s),
        .fill      (pk_fill_s)
    );

    // Next-state logic; dout_valid is derived from the post-update fill so
    // the registered valid lines up with the registered buffer head.
    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        pk_load_s      = 1'b0;
        pk_shift_s     = 1'b0;
        pk_load_bits_s = W_F;
        fill_next_s    = pk_fill_s;
        all_loaded_s   = (word_q == D_W);
        valid_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    word_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pk_load_s = 1'b1;
                if (word_q == LAST_WORD) begin
                    pk_load_bits_s = LAST_BITS_F;
                end else begin
                    pk_load_bits_s = W_F;
                end
                fill_next_s  = pk_fill_s + pk_load_bits_s;
                word_d       = word_q + wcnt_t'(1);
                all_loaded_s = (word_d == D_W);
                valid_d      = beat_pending(fill_next_s, all_loaded_s);
                state_d      = ST_DRAIN;
            end
            ST_DRAIN: begin
                pk_shift_s = handshake_s;
                if (handshake_s) begin
                    fill_next_s = pk_fill_s - beat_take(pk_fill_s);
                end else begin
                    fill_next_s = pk_fill_s;
                end
                valid_d = beat_pending(fill_next_s, all_loaded_s);
                if (valid_d) begin
                    state_d = ST_DRAIN;
                end else if (!all_loaded_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_FIN);
        rd_d   = (state_d == ST_FETCH);
        if (rd_d) begin
            addr_d = ADDR_W'(word_d);
        end else begin
            addr_d = '0;
        end
`ifdef CT_SER_LAST_EN
        last_d = valid_d && beat_is_last(fill_next_s, all_loaded_s);
`endif
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
`ifdef CT_SER_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
`ifdef CT_SER_LAST_EN
            last_q  <= last_d;
`endif
        end
    end

    assign ct_addr            = addr_q;
    assign ct_rd              = rd_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign dout_if.dout       = pk_head_s;
    assign dout_if.dout_valid = valid_q;
`ifdef CT_SER_LAST_EN
    assign dout_if.dout_last  = last_q;
`endif

endmodule

// File: tb/tb_ct_serializer.sv
// ---------------------------------------------------------------------------
// tb_ct_serializer
// Self-checking bench for ct_serializer: a ct memory model with synchronous
// read, a reference packing of the N*M ciphertext bits into beats, and one
// task per scenario. Define CT_SER_LAST_EN to also check dout_last.
// ---------------------------------------------------------------------------
module tb_ct_serializer;

    localparam int TM     = 79;
    localparam int TN     = 47;
    localparam int TDIGIT = 4;
    localparam int TOUT   = 32;
    localparam int TW     = TM * TDIGIT;
    localparam int TD     = 12;
    localparam int TBEATS = 117;
    localparam int TDONE  = 2 * TD + TBEATS + 1;

    logic          clk;
    logic          rst_b;
    logic          start;
    logic [3:0]    ct_addr;
    logic          ct_rd;
    logic [TW-1:0] ct_din;
    logic          busy;
    logic          done;

    ct_serializer_if sif ();

    ct_serializer dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .ct_addr (ct_addr),
        .ct_rd   (ct_rd),
        .ct_din  (ct_din),
        .dout_if (sif),
        .busy    (busy),
        .done    (done)
    );

    int errors = 0;
    int checks = 0;

    logic [TW-1:0]   mem [TD];
    logic [TOUT-1:0] exp_q [$];
    logic [TOUT-1:0] got_q [$];
    int              addr_seq [$];
    int stall_viol, addr_viol, busy_viol, last_viol;
    int done_cnt, done_cyc, done_gap, first_valid_cyc;
    bit timed_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TW-1:0] rand_word();
        logic [TW-1:0] r;
        logic [31:0]   t;
        t = 32'd0;
        for (int i = 0; i < TW; i++) begin
            if (i % 32 == 0) t = $urandom;
            r[i] = t[i % 32];
        end
        return r;
    endfunction

    // ct memory: synchronous read; garbage on the bus when not reading
    always @(posedge clk) begin
        if (ct_rd) ct_din <= mem[ct_addr];
        else       ct_din <= rand_word();
    end

    task automatic fill_pattern();
        logic [31:0] pat;
        for (int a = 0; a < TD; a++) begin
            pat = 32'(a) * 32'h01010101;
            for (int i = 0; i < TW; i++) mem[a][i] = pat[i % 32];
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < TD; a++) mem[a] = rand_word();
    endtask

    // Reference: element e lands at stream bits [e*M +: M]; beats are
    // consecutive 32-bit slices, tail zero-padded.
    task automatic build_expected();
        logic [TBEATS*TOUT-1:0] s;
        int a, j;
        s = '0;
        for (int e = 0; e < TN; e++) begin
            a = e / TDIGIT;
            j = e % TDIGIT;
            for (int b = 0; b < TM; b++) s[e*TM + b] = mem[a][j*TM + b];
        end
        exp_q.delete();
        for (int k = 0; k < TBEATS; k++) exp_q.push_back(s[k*TOUT +: TOUT]);
    endtask

    // Drives start, runs the sink and records what the DUT does per cycle.
    task automatic run_stream(input int ready_pct, input int restart_at, input int stop_at);
        int cyc, post, last_hs_cyc;
        bit prev_valid, prev_hs, done_seen, restarted, v, rdy, hs, fin;
        logic [TOUT-1:0] prev_dout, d;
        got_q.delete(); addr_seq.delete();
        stall_viol = 0; addr_viol = 0; busy_viol = 0; last_viol = 0;
        done_cnt = 0; done_cyc = -1; done_gap = -1; first_valid_cyc = -1;
        timed_out = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; prev_dout = '0;
        done_seen = 1'b0; restarted = 1'b0; post = 0; last_hs_cyc = -1; fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            v = sif.dout_valid;
            d = sif.dout;
            if (prev_valid && !prev_hs && (!v || d !== prev_dout)) stall_viol++;
            if (!ct_rd && ct_addr !== 4'd0) addr_viol++;
            if (ct_rd) addr_seq.push_back(int'(ct_addr));
            if (v && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    done_gap = cyc - last_hs_cyc;
                end
                done_seen = 1'b1;
            end
            if (!done_seen && !busy) busy_viol++;
            if (done_seen && busy) busy_viol++;
`ifdef CT_SER_LAST_EN
            if (sif.dout_last !== (v && got_q.size() == TBEATS - 1)) last_viol++;
`endif
            rdy = ($urandom_range(99) < ready_pct);
            sif.dout_ready = rdy;
            hs = v && rdy;
            if (hs) begin
                got_q.push_back(d);
                last_hs_cyc = cyc;
            end
            if (restart_at >= 0 && !restarted && got_q.size() == restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            prev_valid = v; prev_hs = hs; prev_dout = d;
            if (done_seen) post++;
            if (post >= 3) fin = 1'b1;
            if (stop_at >= 0 && got_q.size() >= stop_at) fin = 1'b1;
            if (cyc > 5000) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end
        end
    endtask

    task automatic compare_beats(input string tag);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s timeout: no done within cycle budget", tag);
        end
        checks++;
        if (got_q.size() != TBEATS) begin
            errors++;
            $display("FAIL %s beat_count: got %0d want %0d", tag, got_q.size(), TBEATS);
        end
        for (int k = 0; k < TBEATS; k++) begin
            checks++;
            if (k >= got_q.size()) begin
                errors++;
                $display("FAIL %s beat%0d: missing, want %h", tag, k, exp_q[k]);
            end else if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s beat%0d: got %h want %h", tag, k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0; start = 1'b0; sif.dout_ready = 1'b0;
        #12;
        checks++;
        if ({ct_addr, ct_rd, busy, done, sif.dout_valid} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got addr=%h rd=%b busy=%b done=%b valid=%b want all 0",
                     ct_addr, ct_rd, busy, done, sif.dout_valid);
        end
        checks++;
        if (sif.dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_dout: got %h want 0", sif.dout);
        end
`ifdef CT_SER_LAST_EN
        checks++;
        if (sif.dout_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_last: got %b want 0", sif.dout_last);
        end
`endif
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_patterned_stream();
        fill_pattern();
        build_expected();
        run_stream(100, -1, -1);
        compare_beats("pattern");
        checks++;
        if (first_valid_cyc != 3) begin
            errors++;
            $display("FAIL first_valid: got cycle %0d want 3", first_valid_cyc);
        end
        checks++;
        if (got_q.size() == TBEATS && got_q[TBEATS-1][31:1] !== 31'd0) begin
            errors++;
            $display("FAIL tail_pad: got %h want upper 31 bits zero", got_q[TBEATS-1]);
        end
        checks++;
        if (done_gap != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL done_pulse: got gap=%0d count=%0d want gap=1 count=1", done_gap, done_cnt);
        end
        checks++;
        if (done_cyc != TDONE) begin
            errors++;
            $display("FAIL done_cycle: got %0d want %0d", done_cyc, TDONE);
        end
        checks++;
        if (busy_viol != 0) begin
            errors++;
            $display("FAIL busy_window: got %0d bad cycles want 0", busy_viol);
        end
`ifdef CT_SER_LAST_EN
        checks++;
        if (last_viol != 0) begin
            errors++;
            $display("FAIL last_flag: got %0d bad cycles want 0", last_viol);
        end
`endif
    endtask

    task automatic test_random_ready();
        fill_random();
        build_expected();
        run_stream(50, -1, -1);
        compare_beats("rand_ready");
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d unstable stalled cycles want 0", stall_viol);
        end
        checks++;
        if (done_gap != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL rr_done: got gap=%0d count=%0d want gap=1 count=1", done_gap, done_cnt);
        end
`ifdef CT_SER_LAST_EN
        checks++;
        if (last_viol != 0) begin
            errors++;
            $display("FAIL rr_last_flag: got %0d bad cycles want 0", last_viol);
        end
`endif
    endtask

    task automatic test_addr_bus();
        fill_random();
        build_expected();
        run_stream(75, -1, -1);
        compare_beats("addr_bus");
        checks++;
        if (addr_viol != 0) begin
            errors++;
            $display("FAIL addr_idle_zero: got %0d cycles with addr!=0 while not reading want 0", addr_viol);
        end
        checks++;
        if (addr_seq.size() != TD) begin
            errors++;
            $display("FAIL addr_count: got %0d reads want %0d", addr_seq.size(), TD);
        end
        for (int i = 0; i < TD; i++) begin
            checks++;
            if (i >= addr_seq.size()) begin
                errors++;
                $display("FAIL addr_seq%0d: missing want %0d", i, i);
            end else if (addr_seq[i] != i) begin
                errors++;
                $display("FAIL addr_seq%0d: got %0d want %0d", i, addr_seq[i], i);
            end
        end
    endtask

    task automatic test_ignored_start();
        fill_pattern();
        build_expected();
        run_stream(100, 40, -1);
        compare_beats("restart");
        checks++;
        if (busy_viol != 0) begin
            errors++;
            $display("FAIL restart_busy: got %0d bad cycles want 0", busy_viol);
        end
        checks++;
        if (done_cyc != TDONE || done_cnt != 1) begin
            errors++;
            $display("FAIL restart_done: got cycle=%0d count=%0d want cycle=%0d count=1", done_cyc, done_cnt, TDONE);
        end
    endtask

    task automatic test_reset_mid_stream();
        fill_random();
        build_expected();
        run_stream(100, -1, 60);
        checks++;
        if (got_q.size() != 60) begin
            errors++;
            $display("FAIL pre_reset_beats: got %0d want 60", got_q.size());
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if ({ct_addr, ct_rd, busy, done, sif.dout_valid} !== 8'd0 || sif.dout !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got addr=%h rd=%b busy=%b done=%b valid=%b dout=%h want all 0",
                     ct_addr, ct_rd, busy, done, sif.dout_valid, sif.dout);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || sif.dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold%0d: got done=%b valid=%b want 0 0", c, done, sif.dout_valid);
            end
        end
        rst_b = 1'b1;
        run_stream(100, -1, -1);
        compare_beats("after_reset");
        checks++;
        if (done_cyc != TDONE) begin
            errors++;
            $display("FAIL after_reset_done: got %0d want %0d", done_cyc, TDONE);
        end
    endtask

    initial begin
        test_reset();
        test_patterned_stream();
        test_random_ready();
        test_addr_bus();
        test_ignored_start();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
